operand_entry: RTL

- Keypad-facing front end of the calculator datapath.
- Assembles two 8-bit hex operands from single-key events and presents them as nibble pairs {a1,a0} and {b1,b0}.
- These feed the nibble-split adder stage directly.
- Holds the operands stable under a valid/ready handshake so the downstream result register can capture the sum.

---
 rtl/calc_pkg.sv | 23 ++
 rtl/operand_entry_if.sv | 30 +++
 rtl/operand_entry_hex_digit_reg.sv | 37 +++
 rtl/operand_entry.sv | 135 +++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared key codes, state encoding and widths for the calculator front end
package calc_pkg;

   localparam int KEY_W       = 5;
   localparam int NIBBLE_W    = 4;
   localparam int OPER_W      = 2 * NIBBLE_W;

   localparam logic [KEY_W-1:0] CODE_ENTER = 5'h10;
   localparam logic [KEY_W-1:0] CODE_CLEAR = 5'h11;
   localparam logic [KEY_W-1:0] CODE_BKSP  = 5'h12;
   localparam logic [KEY_W-1:0] DIGIT_MAX  = 5'h0F;

   typedef enum logic [1:0] {
      S_A,
      S_B,
      S_HOLD
   } state_t;

   function automatic logic is_digit(input logic [KEY_W-1:0] code);
      return code <= DIGIT_MAX;
   endfunction

endpackage

// File: rtl/operand_entry_if.sv
// rtl/operand_entry_if.sv - operand pair handshake toward the nibble-split adder
interface operand_entry_if;
   import calc_pkg::*;

   logic                ops_valid;
   logic                ops_ready;
   logic [NIBBLE_W-1:0] a0;
   logic [NIBBLE_W-1:0] a1;
   logic [NIBBLE_W-1:0] b0;
   logic [NIBBLE_W-1:0] b1;

   modport master (
      output ops_valid,
      output a0,
      output a1,
      output b0,
      output b1,
      input  ops_ready
   );

   modport slave (
      input  ops_valid,
      input  a0,
      input  a1,
      input  b0,
      input  b1,
      output ops_ready
   );

endinterface

// File: rtl/operand_entry_hex_digit_reg.sv
// rtl/operand_entry_hex_digit_reg.sv - two-digit hex shift register with digit count
module hex_digit_reg
   import calc_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                push,
   input  logic                pop,
   input  logic                clr,
   input  logic [NIBBLE_W-1:0] digit,
   output logic [OPER_W-1:0]   value,
   output logic [1:0]          count,
   output logic                full,
   output logic                empty
);

   assign full  = (count == 2'd2);
   assign empty = (count == 2'd0);

   // clr wins over push, push over pop; saturating at both ends
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value <= '0;
         count <= 2'd0;
      end else if (clr) begin
         value <= '0;
         count <= 2'd0;
      end else if (push && !full) begin
         value <= {value[NIBBLE_W-1:0], digit};
         count <= count + 2'd1;
      end else if (pop && !empty) begin
         value <= {{NIBBLE_W{1'b0}}, value[OPER_W-1:NIBBLE_W]};
         count <= count - 2'd1;
      end
   end

endmodule

// File: rtl/operand_entry.sv
// rtl/operand_entry.sv - keypad operand assembly FSM holding an A/B pair under valid/ready
module operand_entry
   import calc_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  key_valid,
   input  logic [KEY_W-1:0]      key_code,
   operand_entry_if.master       ops,
   output logic [OPER_W-1:0]     disp_val,
   output logic                  disp_sel,
   output logic                  key_err
);

   state_t              state, state_nxt;
   logic                valid_q, valid_nxt;
   logic                err_nxt;
   logic                push_a, pop_a, push_b, pop_b, clr_all;
   logic                transfer;
   logic [OPER_W-1:0]   val_a, val_b;
   logic [1:0]          cnt_a, cnt_b;
   logic                full_a, empty_a, full_b, empty_b;

   hex_digit_reg u_reg_a (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_a),
      .pop   (pop_a),
      .clr   (clr_all),
      .digit (key_code[NIBBLE_W-1:0]),
      .value (val_a),
      .count (cnt_a),
      .full  (full_a),
      .empty (empty_a)
   );

   hex_digit_reg u_reg_b (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_b),
      .pop   (pop_b),
      .clr   (clr_all),
      .digit (key_code[NIBBLE_W-1:0]),
      .value (val_b),
      .count (cnt_b),
      .full  (full_b),
      .empty (empty_b)
   );

   assign transfer = (state == S_HOLD) && valid_q && ops.ops_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_A;
         valid_q <= 1'b0;
         key_err <= 1'b0;
      end else begin
         state   <= state_nxt;
         valid_q <= valid_nxt;
         key_err <= err_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      valid_nxt = valid_q;
      err_nxt   = 1'b0;
      push_a    = 1'b0;
      pop_a     = 1'b0;
      push_b    = 1'b0;
      pop_b     = 1'b0;
      clr_all   = 1'b0;

      // a transfer always completes; any non-CLEAR key on that edge is still a held-state reject
      if (transfer) begin
         state_nxt = S_A;
         valid_nxt = 1'b0;
         clr_all   = 1'b1;
         err_nxt   = key_valid && (key_code != CODE_CLEAR);
      end else if (key_valid) begin
         if (key_code == CODE_CLEAR) begin
            state_nxt = S_A;
            valid_nxt = 1'b0;
            clr_all   = 1'b1;
         end else if (key_code > CODE_BKSP) begin
            err_nxt = 1'b1;
         end else begin
            unique case (state)
               S_A: begin
                  if (is_digit(key_code)) begin
                     if (full_a) err_nxt = 1'b1;
                     else        push_a  = 1'b1;
                  end else if (key_code == CODE_BKSP) begin
                     pop_a = 1'b1;
                  end else begin
                     state_nxt = S_B;
                  end
               end
               S_B: begin
                  if (is_digit(key_code)) begin
                     if (full_b) err_nxt = 1'b1;
                     else        push_b  = 1'b1;
                  end else if (key_code == CODE_BKSP) begin
                     if (empty_b) state_nxt = S_A;
                     else         pop_b     = 1'b1;
                  end else begin
                     state_nxt = S_HOLD;
                     valid_nxt = 1'b1;
                  end
               end
               S_HOLD: begin
                  err_nxt = 1'b1;
               end
               default: begin
                  state_nxt = S_A;
               end
            endcase
         end
      end
   end

   assign ops.ops_valid = valid_q;
   assign ops.a0        = val_a[NIBBLE_W-1:0];
   assign ops.a1        = val_a[OPER_W-1:NIBBLE_W];
   assign ops.b0        = val_b[NIBBLE_W-1:0];
   assign ops.b1        = val_b[OPER_W-1:NIBBLE_W];
   assign disp_sel      = (state == S_B);
   assign disp_val      = (state == S_B) ? val_b : val_a;

   // digit-count flags must track the counts they are derived from
   assert property (@(posedge clk) disable iff (!rst_n)
      (full_a == (cnt_a == 2'd2)) && (empty_a == (cnt_a == 2'd0)) &&
      (full_b == (cnt_b == 2'd2)) && (empty_b == (cnt_b == 2'd0)));

endmodule
